// File: rtl/stack_op_sequencer.sv
// Command-side sequencer for the register stack: turns one request into action pulses.
// Optional STK_SEQ_DEPTH_EN adds a depth counter, the depth port and under/overflow rejection.
module stack_op_sequencer #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned DEPTH      = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [2:0]            req_op,
    input  logic [DATA_WIDTH-1:0] req_imm,
    input  logic [DATA_WIDTH-1:0] stk_top,
    input  logic [DATA_WIDTH-1:0] stk_next,
    output logic [3:0]            stackAction,
    output logic [DATA_WIDTH-1:0] in_val,
    output logic                  done,
    output logic                  err
`ifdef STK_SEQ_DEPTH_EN
    ,
    output logic [$clog2(DEPTH+1)-1:0] depth
`endif
);

    localparam logic [2:0] StIdle = 3'd0;
    localparam logic [2:0] StAct1 = 3'd1;
    localparam logic [2:0] StGap1 = 3'd2;
    localparam logic [2:0] StAct2 = 3'd3;
    localparam logic [2:0] StGap2 = 3'd4;

    localparam logic [2:0] OpNop  = 3'b000;
    localparam logic [2:0] OpPush = 3'b001;
    localparam logic [2:0] OpPop  = 3'b010;
    localparam logic [2:0] OpDrop = 3'b011;
    localparam logic [2:0] OpDup  = 3'b100;
    localparam logic [2:0] OpSwap = 3'b101;
    localparam logic [2:0] OpOver = 3'b110;
    localparam logic [2:0] OpNip  = 3'b111;

    localparam logic [3:0] ActIdle = 4'b0000;
    localparam logic [3:0] ActPush = 4'b1000;
    localparam logic [3:0] ActPop  = 4'b0001;
    localparam logic [3:0] ActDrop = 4'b0010;
    localparam logic [3:0] ActDup  = 4'b0101;
    localparam logic [3:0] ActSwap = 4'b0111;

    logic [2:0]            state_q, state_d;
    logic [2:0]            op_q;
    logic                  rej_q;
    logic [DATA_WIDTH-1:0] in_val_q;
    logic                  accept;
    logic                  ok;
    logic                  nip_cont;

    logic unused_top;
    assign unused_top = ^stk_top;

    assign accept    = (state_q == StIdle) && req_valid;
    assign req_ready = (state_q == StIdle) && !rst;
    assign nip_cont  = (op_q == OpNip) && !rej_q;

`ifdef STK_SEQ_DEPTH_EN
    localparam int unsigned           DepthW   = $clog2(DEPTH + 1);
    localparam logic [DepthW-1:0]     DepthMax = DepthW'(DEPTH);

    logic [DepthW-1:0] depth_q, depth_d;
    logic              inc_q, dec_q;
    logic              upd;

    always_comb begin
        ok = 1'b1;
        case (req_op)
            OpPush:        ok = depth_q < DepthMax;
            OpPop, OpDrop: ok = depth_q != '0;
            OpDup:         ok = (depth_q != '0) && (depth_q < DepthMax);
            OpSwap, OpNip: ok = depth_q > DepthW'(1);
            OpOver:        ok = (depth_q > DepthW'(1)) && (depth_q < DepthMax);
            default:       ok = 1'b1;
        endcase
    end

    // Depth moves on the edge into the done cycle so it is visible together with done.
    assign upd = ((state_q == StAct1) && (op_q != OpNip)) || (state_q == StAct2);

    always_comb begin
        depth_d = depth_q;
        if (upd && inc_q && (depth_q != DepthMax)) begin
            depth_d = depth_q + DepthW'(1);
        end else if (upd && dec_q && (depth_q != '0)) begin
            depth_d = depth_q - DepthW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            depth_q <= '0;
            inc_q   <= 1'b0;
            dec_q   <= 1'b0;
        end else begin
            depth_q <= depth_d;
            if (accept) begin
                inc_q <= ok && (req_op inside {OpPush, OpDup, OpOver});
                dec_q <= ok && (req_op inside {OpPop, OpDrop, OpNip});
            end
        end
    end

    assign depth = depth_q;
`else
    logic [31:0] unused_depth;
    assign unused_depth = DEPTH;
    assign ok = 1'b1;
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle: begin
                if (accept) begin
                    state_d = ((req_op == OpNop) || !ok) ? StGap1 : StAct1;
                end
            end
            StAct1:  state_d = StGap1;
            StGap1:  state_d = nip_cont ? StAct2 : StIdle;
            StAct2:  state_d = StGap2;
            StGap2:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= StIdle;
            op_q     <= OpNop;
            rej_q    <= 1'b0;
            in_val_q <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                op_q  <= req_op;
                rej_q <= !ok;
                if (req_op == OpPush) begin
                    in_val_q <= req_imm;
                end else if (req_op == OpOver) begin
                    in_val_q <= stk_next;
                end
            end
        end
    end

    always_comb begin
        stackAction = ActIdle;
        if (state_q == StAct1) begin
            case (op_q)
                OpPush, OpOver: stackAction = ActPush;
                OpPop:          stackAction = ActPop;
                OpDrop:         stackAction = ActDrop;
                OpDup:          stackAction = ActDup;
                OpSwap, OpNip:  stackAction = ActSwap;
                default:        stackAction = ActIdle;
            endcase
        end else if (state_q == StAct2) begin
            stackAction = ActPop;
        end
    end

    assign in_val = in_val_q;
    assign done   = ((state_q == StGap1) && !nip_cont) || (state_q == StGap2);
    assign err    = done && rej_q;

endmodule
